instruction_fetch_unit: RTL and testbench

- Program-counter and fetch sequencer directly upstream of the 4 KB instruction memory.
- Drives the word-aligned byte address into the instruction memory and holds it stable for the memory's sampling window.
- Captures the returned instruction and presents it, with its PC, to decode over a valid/ready handshake.
- Accepts redirects (branch/jump) from downstream and keeps a retired-fetch counter.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/instruction_fetch_unit.sv | 109 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic {FETCH, VALID} fetch_state_t;

    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned WORD_BYTES  = 4;
    localparam logic [INSTR_WIDTH-1:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_unit.sv
// PC register and fetch sequencer: holds the address for MEM_LATENCY clocks, captures the
// returned word and presents it to decode over valid/ready; redirects override everything.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
    parameter int unsigned            MEM_LATENCY = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [ADDR_WIDTH-1:0]  address,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_target,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [INSTR_WIDTH-1:0] out_instruction,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic                   align_fault,
    output logic [31:0]            fetch_count
);

    localparam int unsigned      CntW    = $clog2(MEM_LATENCY + 1);
    localparam logic [CntW-1:0]  CntLast = CntW'(MEM_LATENCY - 1);

    fetch_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
    logic [ADDR_WIDTH-1:0]  out_pc_q, out_pc_d;
    logic                   fault_q, fault_d;
    logic [31:0]            fetch_count_q, fetch_count_d;
    logic                   handshake;

    assign handshake = (state_q == VALID) && out_valid_q && out_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cnt_d         = cnt_q;
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        fault_d       = 1'b0;
        fetch_count_d = handshake ? fetch_count_q + 32'd1 : fetch_count_q;

        // A redirect still lets a coincident handshake retire; only the next PC changes.
        if (redirect_valid) begin
            pc_d        = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
            cnt_d       = '0;
            out_valid_d = 1'b0;
            state_d     = FETCH;
            fault_d     = |redirect_target[1:0];
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (cnt_q == CntLast) begin
                        out_instr_d = instruction;
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = VALID;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                VALID: begin
                    if (handshake) begin
                        pc_d        = pc_q + ADDR_WIDTH'(WORD_BYTES);
                        out_valid_d = 1'b0;
                        state_d     = FETCH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_instr_q   <= NOP;
            out_pc_q      <= '0;
            fault_q       <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign address         = pc_q;
    assign out_valid       = out_valid_q;
    assign out_instruction = out_instr_q;
    assign out_pc          = out_pc_q;
    assign align_fault     = fault_q;
    assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: cycle table after reset plus corner-case sequences.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        align_fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit #(
        .ADDR_WIDTH  (32),
        .RESET_PC    (32'h0000_0000),
        .MEM_LATENCY (6)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .address         (address),
        .instruction     (instruction),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .align_fault     (align_fault),
        .fetch_count     (fetch_count)
    );

    always #5 clock = ~clock;

    // Memory model: each word is a distinct function of its address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign instruction = word_at(address);

    typedef struct {
        logic        rv;
        logic [31:0] tgt;
        logic        rdy;
        logic        ev;
        logic [31:0] ea;
        logic [31:0] epc;
        logic [31:0] efc;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic rv, input logic [31:0] tgt, input logic rdy,
                           input logic ev, input logic [31:0] ea, input logic [31:0] epc,
                           input logic [31:0] efc);
        vec_t v;
        v.rv = rv; v.tgt = tgt; v.rdy = rdy; v.ev = ev; v.ea = ea; v.epc = epc; v.efc = efc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Ticks until out_valid rises or the budget runs out; n is the tick count taken.
    task automatic wait_valid(input string name, input int max, output int n);
        n = 0;
        while (!out_valid && n < max) begin
            tick();
            n++;
        end
        check({name, " valid seen"}, {31'b0, out_valid}, 32'd1);
    endtask

    initial begin
        int n;
        logic [31:0] held_instr;

        // Power-on reset: expected sequence with out_ready held high.
        for (int k = 1; k <= 5; k++) add_vec(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 32'd0);
        add_vec(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 32'd0);
        add_vec(1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 32'd1);
        for (int k = 8; k <= 12; k++) add_vec(1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 32'd1);
        add_vec(1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 32'h4, 32'd1);
        add_vec(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h4, 32'd2);

        #12;
        check("reset address", address, 32'h0);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset out_instruction", out_instruction, 32'h0);
        check("reset out_pc", out_pc, 32'h0);
        check("reset align_fault", {31'b0, align_fault}, 32'd0);
        check("reset fetch_count", fetch_count, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            redirect_valid  = vecs[i].rv;
            redirect_target = vecs[i].tgt;
            out_ready       = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ev});
            check($sformatf("vec%0d address", i), address, vecs[i].ea);
            check($sformatf("vec%0d out_pc", i), out_pc, vecs[i].epc);
            check($sformatf("vec%0d fetch_count", i), fetch_count, vecs[i].efc);
            if (vecs[i].ev)
                check($sformatf("vec%0d out_instruction", i), out_instruction,
                      word_at(vecs[i].epc));
        end

        // Backpressure at pc=0x8.
        out_ready = 1'b0;
        wait_valid("bp", 20, n);
        check("bp latency", n, 32'd6);
        check("bp out_pc", out_pc, 32'h8);
        held_instr = out_instruction;
        check("bp instr", held_instr, word_at(32'h8));
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("bp hold%0d valid", k), {31'b0, out_valid}, 32'd1);
            check($sformatf("bp hold%0d instr", k), out_instruction, held_instr);
            check($sformatf("bp hold%0d pc", k), out_pc, 32'h8);
            check($sformatf("bp hold%0d address", k), address, 32'h8);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release count", fetch_count, 32'd3);
        check("bp release address", address, 32'hC);
        check("bp release valid", {31'b0, out_valid}, 32'd0);

        // Redirect to 0x40 with the latency counter at 3.
        tick();
        tick();
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        tick();
        redirect_valid  = 1'b0;
        check("rf valid", {31'b0, out_valid}, 32'd0);
        check("rf address", address, 32'h40);
        check("rf fault", {31'b0, align_fault}, 32'd0);
        wait_valid("rf", 20, n);
        check("rf latency", n, 32'd6);
        check("rf out_pc", out_pc, 32'h40);
        check("rf count", fetch_count, 32'd3);

        // Redirect coincident with a handshake at pc=0x18.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hs 0x40 count", fetch_count, 32'd4);
        redirect_valid  = 1'b1;
        redirect_target = 32'h18;
        tick();
        redirect_valid  = 1'b0;
        wait_valid("co", 20, n);
        check("co out_pc", out_pc, 32'h18);
        redirect_valid  = 1'b1;
        redirect_target = 32'h28;
        out_ready       = 1'b1;
        tick();
        redirect_valid  = 1'b0;
        out_ready       = 1'b0;
        check("co count", fetch_count, 32'd5);
        check("co address", address, 32'h28);
        check("co valid", {31'b0, out_valid}, 32'd0);
        check("co kept instr", out_instruction, word_at(32'h18));

        // Misaligned redirect.
        redirect_valid  = 1'b1;
        redirect_target = 32'h33;
        tick();
        redirect_valid  = 1'b0;
        check("mis fault", {31'b0, align_fault}, 32'd1);
        check("mis address", address, 32'h30);
        tick();
        check("mis fault pulse", {31'b0, align_fault}, 32'd0);

        // Async reset mid-fetch at pc=0x5C.
        redirect_valid  = 1'b1;
        redirect_target = 32'h5C;
        tick();
        redirect_valid  = 1'b0;
        tick();
        tick();
        check("pre-reset address", address, 32'h5C);
        #3 reset = 1'b1;
        #1;
        check("ar address", address, 32'h0);
        check("ar valid", {31'b0, out_valid}, 32'd0);
        check("ar out_pc", out_pc, 32'h0);
        check("ar instr", out_instruction, 32'h0);
        check("ar count", fetch_count, 32'd0);
        #1 reset = 1'b0;
        tick();

        // PC wrap from 0xFFFF_FFFC.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid  = 1'b0;
        wait_valid("wrap", 20, n);
        check("wrap out_pc", out_pc, 32'hFFFF_FFFC);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("wrap address", address, 32'h0);
        check("wrap fault", {31'b0, align_fault}, 32'd0);
        check("wrap count", fetch_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
